// File: rtl/pipo_ctrl_pkg.sv
// Purpose : shared definitions for the PIPO load arbiter slice: FSM state
//           encoding, default geometry and a constant clog2 helper.
// Contents: pipo_state_e, DEF_N_REQ, DEF_W, DEF_HOLD_CYCLES, HOLD_CNT_W, clog2()
package pipo_ctrl_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_W           = 4;
  localparam int DEF_HOLD_CYCLES = 3;
  // Wide enough for the largest legal hold length (15).
  localparam int HOLD_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } pipo_state_e;

  // Ceiling log2 for elaboration-time sizing; never returns less than 1 so a
  // two-requester arbiter still gets a one-bit owner index.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pipo_load_arbiter_chk.sv
// Purpose : property checker for pipo_load_arbiter, bound by the instantiating
//           environment to the arbiter's outputs.
// Ports   : clk, rst      - same clock/reset as the arbiter
//           gnt, q        - arbiter grant vector and register contents
//           q_valid, busy - arbiter status outputs
module pipo_load_arbiter_chk #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] gnt,
  input logic [W-1:0]     q,
  input logic             q_valid,
  input logic             busy
);

  logic         r_seen_rst;
  logic         r_rst_prev;
  logic         r_load_prev;
  logic [W-1:0] r_q_prev;

  // One-cycle history of reset, load (a grant closes a load) and q.
  always_ff @(posedge clk) begin
    r_seen_rst  <= r_seen_rst | rst;
    r_rst_prev  <= rst;
    r_load_prev <= |gnt;
    r_q_prev    <= q;
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_valid_busy: assert property (@(posedge clk) disable iff (rst) q_valid |-> busy);

  // q may only move on the edge that closes a granted LOAD, or on reset.
  a_q_stable: assert property (@(posedge clk)
    (r_seen_rst && !r_rst_prev && !r_load_prev) |-> (q == r_q_prev));

endmodule

// File: rtl/pipo_reg.sv
// Purpose : W-bit parallel-in / parallel-out register with synchronous
//           active-high reset and a load enable. Reset wins over load.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset (clears q)
//           i_en - load enable, q takes i_d on the rising edge
//           i_d  - parallel data in
//           o_q  - parallel data out
module pipo_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Storage: reset clears, enable loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Purpose : round-robin arbiter that lets one of N_REQ requesters load its
//           word into a shared W-bit register, then holds the result valid
//           for HOLD_CYCLES cycles before accepting the next request.
// Ports   : clk     - clock, all state on the rising edge
//           rst     - synchronous active-high reset
//           req     - per-requester load request (bit k = requester k)
//           data_in - requester k's word at [k*W +: W]
//           gnt     - one-hot grant, only in the LOAD cycle that loads
//           q       - shared register contents
//           q_valid - high during HOLD
//           owner   - index of the requester that last won / is served
//           busy    - high in LOAD and HOLD
module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter int  N_REQ       = DEF_N_REQ,
  parameter int  W           = DEF_W,
  parameter int  HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int OW          = clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       q,
  output logic               q_valid,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  pipo_state_e             r_state;
  pipo_state_e             w_state_nxt;
  logic [OW-1:0]           r_owner;
  logic [OW-1:0]           w_owner_nxt;
  logic [OW-1:0]           r_ptr;
  logic [OW-1:0]           w_ptr_nxt;
  logic [HOLD_CNT_W-1:0]   r_hold_cnt;
  logic [HOLD_CNT_W-1:0]   w_hold_nxt;
  logic [N_REQ-1:0]        w_gnt;
  logic                    w_load_en;
  logic [W-1:0]            w_sel_data;
  logic [2*N_REQ-1:0]      w_req_dbl;
  logic [N_REQ-1:0]        w_req_rot;
  logic [OW-1:0]           w_off;
  logic [OW:0]             w_sum;
  logic [OW-1:0]           w_win;

  // Round-robin pick: rotate req so ptr lands on bit 0, take the lowest set
  // bit, then add ptr back modulo N_REQ.
  always_comb begin
    w_req_dbl = {req, req} >> r_ptr;
    w_req_rot = w_req_dbl[N_REQ-1:0];
    w_off     = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_off = OW'(j);
      end else begin
        w_off = w_off;
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (OW+1)'(N_REQ)) begin
      w_sum = w_sum - (OW+1)'(N_REQ);
    end else begin
      w_sum = w_sum;
    end
    w_win = w_sum[OW-1:0];
  end

  assign w_sel_data = data_in[int'(r_owner)*W +: W];

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_gnt       = '0;
    w_load_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_win;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A withdrawn request abandons the load without touching q or ptr.
        if (req[r_owner]) begin
          w_gnt[r_owner] = 1'b1;
          w_load_en      = 1'b1;
          w_ptr_nxt      = (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + OW'(1);
          w_hold_nxt     = HOLD_CNT_W'(HOLD_CYCLES);
          w_state_nxt    = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt <= HOLD_CNT_W'(1)) begin
          w_hold_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_hold_nxt  = r_hold_cnt - HOLD_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  pipo_reg #(
    .W (W)
  ) u_pipo_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_load_en),
    .i_d  (w_sel_data),
    .o_q  (q)
  );

  assign gnt     = w_gnt;
  assign q_valid = (r_state == ST_HOLD);
  assign busy    = (r_state != ST_IDLE);
  assign owner   = r_owner;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Purpose : self-checking bench for pipo_load_arbiter (N_REQ=4, W=4,
//           HOLD_CYCLES=3): directed scenarios plus randomized requesters,
//           all compared cycle by cycle against a transaction-level model.
module tb_pipo_load_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int OW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [OW-1:0]  owner;
  logic           busy;

  always #5 clk = ~clk;

  pipo_load_arbiter #(.N_REQ(N), .W(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  pipo_load_arbiter_chk #(.N_REQ(N), .W(W)) u_chk (
    .clk(clk), .rst(rst), .gnt(gnt), .q(q), .q_valid(q_valid), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_left = busy cycles remaining in the current transaction
  // (H+1 = the LOAD cycle, H..1 = HOLD cycles, 0 = idle).
  int           m_left  = 0;
  int           m_owner = 0;
  int           m_ptr   = 0;
  logic [W-1:0] m_q     = '0;
  logic [N-1:0] last_gnt;
  logic [N-1:0] grant_log[$];
  logic [N-1:0] pend;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_left = 0; m_owner = 0; m_ptr = 0; m_q = '0;
  endtask

  // One clock cycle: apply inputs, compare outputs to the model, advance it.
  task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rs);
    logic [N-1:0] e_gnt;
    @(negedge clk);
    req = r; data_in = d; rst = rs;
    #1;
    e_gnt = '0;
    if (m_left == H + 1 && r[m_owner]) e_gnt[m_owner] = 1'b1;
    check_val("gnt",     32'(gnt),     32'(e_gnt));
    check_val("q",       32'(q),       32'(m_q));
    check_val("q_valid", 32'(q_valid), 32'(m_left >= 1 && m_left <= H));
    check_val("busy",    32'(busy),    32'(m_left > 0));
    check_val("owner",   32'(owner),   32'(m_owner));
    last_gnt = e_gnt;
    if (e_gnt != '0) grant_log.push_back(e_gnt);
    if (rs) begin
      model_reset();
    end else if (m_left == 0) begin
      if (r != '0) begin
        m_owner = pick(r, m_ptr);
        m_left  = H + 1;
      end
    end else if (m_left == H + 1) begin
      if (r[m_owner]) begin
        m_q    = d[m_owner*W +: W];
        m_ptr  = (m_owner + 1) % N;
        m_left = H;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
    end
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    model_reset();
    tick('0, '0, 1'b1);
    check_val("rst_q", 32'(q), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_owner", 32'(owner), 32'd0);

    // Single request from requester 0, data 1001.
    tick(4'b0001, 16'h0009, 1'b0);
    tick(4'b0001, 16'h0009, 1'b0);
    check_val("single_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) tick('0, 16'h0009, 1'b0);
    check_val("single_q", 32'(q), 32'h9);
    check_val("single_busy", 32'(busy), 32'd0);

    // Round robin from a fresh pointer, all requesters held high.
    tick('0, '0, 1'b1);
    grant_log.delete();
    for (int i = 0; i < 25; i++) tick(4'b1111, 16'hBA98, 1'b0);
    check_val("rr_count", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() == 5) begin
      check_val("rr_g0", 32'(grant_log[0]), 32'h1);
      check_val("rr_g1", 32'(grant_log[1]), 32'h2);
      check_val("rr_g2", 32'(grant_log[2]), 32'h4);
      check_val("rr_g3", 32'(grant_log[3]), 32'h8);
      check_val("rr_g4", 32'(grant_log[4]), 32'h1);
    end
    for (int i = 0; i < 5; i++) tick('0, 16'hBA98, 1'b0);
    check_val("rr_q", 32'(q), 32'h8);

    // Withdrawal: requester 2 asks for one cycle only; pointer stays at 1.
    grant_log.delete();
    tick(4'b0100, 16'h3333, 1'b0);
    tick(4'b0000, 16'h3333, 1'b0);
    check_val("wd_q", 32'(q), 32'h8);
    tick(4'b0000, 16'h3333, 1'b0);
    tick(4'b1111, 16'h7654, 1'b0);
    tick(4'b1111, 16'h7654, 1'b0);
    check_val("wd_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) check_val("wd_next", 32'(grant_log[0]), 32'h2);
    for (int i = 0; i < 4; i++) tick('0, 16'h7654, 1'b0);

    // Reset in the second HOLD cycle.
    tick(4'b0001, 16'h0005, 1'b0);
    tick(4'b0001, 16'h0005, 1'b0);
    tick('0, 16'h0005, 1'b0);
    tick('0, 16'h0005, 1'b1);
    tick('0, 16'h0005, 1'b0);
    check_val("rstmid_q", 32'(q), 32'd0);
    check_val("rstmid_valid", 32'(q_valid), 32'd0);

    // Request from requester 1 arriving while requester 0 is held.
    grant_log.delete();
    tick(4'b0001, 16'h00C3, 1'b0);
    tick(4'b0001, 16'h00C3, 1'b0);
    for (int i = 0; i < 5; i++) tick(4'b0010, 16'h00C3, 1'b0);
    for (int i = 0; i < 5; i++) tick('0, 16'h00C3, 1'b0);
    check_val("busy_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) check_val("busy_second", 32'(grant_log[1]), 32'h2);
    check_val("busy_q", 32'(q), 32'hC);

    // Randomized requesters: hold until granted, occasional withdrawal/reset.
    pend = '0;
    for (int i = 0; i < 800; i++) begin
      logic rs;
      rs = ($urandom_range(0, 79) == 0);
      pend = pend | (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) pend = pend & N'($urandom);
      tick(pend, 16'($urandom), rs);
      pend = pend & ~last_gnt;
      if (rs) pend = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipo_load_arbiter.md
PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter W, default 4, meaning the shared register width in bits.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 3, meaning the number of cycles q is held valid after a load (legal range 1..15).
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  N_REQ  per-requester load request; bit k belongs to requester k.
REQ-007 data_in  in  N_REQ*W  requester k's word at bits [k*W +: W].
REQ-008 gnt  out  N_REQ  one-hot grant, high only in LOAD.
REQ-009 q  out  W  shared parallel register contents.
REQ-010 q_valid  out  1  high while in HOLD.
REQ-011 owner  out  clog2(N_REQ)  index of the requester that last won or is being served.
REQ-012 busy  out  1  high in LOAD and HOLD.

Function
REQ-013 FSM states SHALL be IDLE, LOAD and HOLD, held in a registered state variable.
REQ-014 IDLE with req==0 SHALL remain IDLE.
REQ-015 IDLE with any req bit set SHALL pick a winner round-robin: the first set bit at or after ptr, wrapping at N_REQ-1 -> 0.
REQ-016 On that edge the FSM SHALL latch the winner into owner and move to LOAD.
REQ-017 In LOAD with req[owner]==1: gnt[owner]=1 for exactly that cycle; q captures data_in slice of owner on the closing edge; ptr becomes (owner+1) mod N_REQ; next state is HOLD.
REQ-018 In LOAD with req[owner]==0 (request withdrawn): gnt stays 0; q and ptr stay unchanged; next state is IDLE.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles, using a down-counter loaded on LOAD exit, then return to IDLE.
REQ-020 q_valid SHALL be 1 in every HOLD cycle and 0 otherwise.
REQ-021 q SHALL change only on a LOAD-exit edge (REQ-017) or on reset.
REQ-022 Requests arriving during LOAD or HOLD SHALL be ignored until IDLE; a requester keeps req high until it sees gnt.
REQ-023 The block SHALL spend at least one cycle in IDLE between consecutive grants.
REQ-024 Latency: req rising in IDLE at cycle 0 -> gnt high in cycle 1 -> q updated, q_valid high, in cycles 2..1+HOLD_CYCLES -> IDLE in cycle 2+HOLD_CYCLES.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 When rst is high at a rising edge: state=IDLE, q=0, q_valid=0, gnt=0, busy=0, owner=0, ptr=0, hold counter=0.
REQ-027 Reset SHALL take priority over every transition, including mid-LOAD or mid-HOLD: the in-flight load is abandoned with no gnt on the following cycle.

Structure
REQ-028 A shared package pipo_ctrl_pkg SHALL hold the FSM state enum, the default widths, and a clog2 helper constant function.
REQ-029 The datapath register SHALL be a sub-module pipo_reg (W bits, synchronous reset, load enable), instantiated once.
REQ-030 The arbiter/FSM SHALL be in pipo_load_arbiter.

Verification (N_REQ=4, W=4, HOLD_CYCLES=3)
REQ-031 Single request: req=0001, data0=1001 -> gnt=0001 one cycle later; q=1001 with q_valid high for 3 cycles; busy low on the 5th cycle.
REQ-032 Round-robin: req=1111 held, data k=k+8 -> grants in order 0001,0010,0100,1000,0001; q follows 8,9,A,B,8.
REQ-033 Withdrawal: req=0100 for one cycle only -> LOAD entered, gnt stays 0000, q unchanged, back to IDLE, next winner still evaluated from the old ptr.
REQ-034 Reset mid-HOLD: rst pulsed in the 2nd HOLD cycle -> next cycle q=0000, q_valid=0, owner=0, state IDLE.
REQ-035 Busy ignore: req=0010 asserted during HOLD of requester 0 -> no gnt until IDLE, then gnt=0010.
REQ-036 Assertions: gnt is one-hot or zero; q_valid implies busy; q is stable outside LOAD exit and reset.
